// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Result register only
// updates on the done pulse, so downstream display logic never sees partial values.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   BCD
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          r_state, w_state_nx;
    logic [WIDTH-1:0] r_shreg, w_shreg_nx;
    logic [SW-1:0]    r_scratch, w_scratch_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic [SW-1:0]    r_bcd, w_bcd_nx;

    logic [SW-1:0]    w_adj;
    logic [SW-1:0]    w_scr_sh;

    // Digit-local add-3 correction; no carry crosses a digit boundary.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                 r_scratch[4*g +: 4] + 4'd3 : r_scratch[4*g +: 4];
    end

    assign w_scr_sh = {w_adj[SW-2:0], r_shreg[WIDTH-1]};

    always_comb begin
        w_state_nx   = r_state;
        w_shreg_nx   = r_shreg;
        w_scratch_nx = r_scratch;
        w_cnt_nx     = r_cnt;
        w_busy_nx    = r_busy;
        w_done_nx    = 1'b0;
        w_bcd_nx     = r_bcd;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shreg_nx   = bin;
                    w_scratch_nx = '0;
                    w_cnt_nx     = '0;
                    w_busy_nx    = 1'b1;
                    w_state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                w_scratch_nx = w_scr_sh;
                w_shreg_nx   = r_shreg << 1;
                w_cnt_nx     = r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_bcd_nx   = w_scr_sh;
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_shreg   <= w_shreg_nx;
            r_scratch <= w_scratch_nx;
            r_cnt     <= w_cnt_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_bcd     <= w_bcd_nx;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign BCD  = r_bcd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, busy width, start-ignore, reset abort,
// back-to-back throughput and a full 0..255 sweep against a decimal model.
module tb_bin2bcd_seq;
    logic        clock;
    logic        nReset;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] BCD;

    int checks   = 0;
    int failures = 0;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clock (clock),
        .nReset(nReset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .BCD   (BCD)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] dec(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One conversion: lat = edges after the accepting edge until done; bcnt = cycles busy.
    task automatic convert(input logic [7:0] v, input bit clr_bin,
                           output logic [11:0] res, output int lat, output int bcnt);
        @(negedge clock);
        bin   = v;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        if (clr_bin) bin = 8'd0;
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) chk("conv_timeout", 0, 1);
        res = BCD;
    endtask

    logic [11:0] res;
    int          lat, bcnt, dcnt, last, gap;

    initial begin
        nReset = 1'b0;
        start  = 1'b0;
        bin    = 8'd0;
        repeat (3) @(negedge clock);
        nReset = 1'b1;
        @(negedge clock);
        chk("rst_bcd", BCD, 12'h000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // 255 with bin cleared right after acceptance
        convert(8'd255, 1'b1, res, lat, bcnt);
        chk("c255_bcd", res, 12'h255);
        chk("c255_lat", lat, 8);
        chk("c255_busy", bcnt, 8);
        @(negedge clock);
        chk("c255_done_1cyc", done, 0);
        chk("c255_hold", BCD, 12'h255);

        // Full sweep, counting done pulses
        dcnt = 0;
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), 1'b0, res, lat, bcnt);
            if (lat == 8) dcnt++;
            chk($sformatf("sweep_%0d", v), res, dec(v));
        end
        chk("sweep_done_cnt", dcnt, 256);

        // start held high during busy: ignored; re-accepted in the done cycle
        @(negedge clock);
        bin   = 8'd42;
        start = 1'b1;
        @(posedge clock);
        #1 bin = 8'd7;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        chk("hold_lat", lat, 8);
        chk("hold_bcd42", BCD, 12'h042);
        dcnt = 0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clock);
            if (done) dcnt++;
            if (n == 1) chk("b2b_busy", busy, 1);
            if (n < 9) chk("b2b_bcd_stable", BCD, 12'h042);
        end
        chk("b2b_done", done, 1);
        chk("b2b_one_done", dcnt, 1);
        chk("b2b_bcd7", BCD, 12'h007);
        start = 1'b0;
        repeat (10) @(negedge clock);

        // Reset mid-conversion aborts and clears the result
        convert(8'd137, 1'b0, res, lat, bcnt);
        chk("c137_bcd", res, 12'h137);
        @(negedge clock);
        bin   = 8'd250;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1 nReset = 1'b0;
        #1;
        chk("abort_bcd", BCD, 12'h000);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clock);
        nReset = 1'b1;
        repeat (2) @(negedge clock);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_bcd", BCD, 12'h000);
        convert(8'd5, 1'b0, res, lat, bcnt);
        chk("c5_bcd", res, 12'h005);
        chk("c5_lat", lat, 8);

        // Continuous start: done every 9 cycles, result stable between pulses
        @(negedge clock);
        bin   = 8'd63;
        start = 1'b1;
        last  = -1;
        dcnt  = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (done) begin
                if (last >= 0) begin
                    gap = n - last;
                    chk("cont_period", gap, 9);
                end
                last = n;
                dcnt++;
            end
            if (dcnt > 0) chk("cont_bcd", BCD, 12'h063);
        end
        chk("cont_done_cnt", dcnt, 6);
        start = 1'b0;
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
